// File: rtl/alu_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_pkg
// Purpose  : Shared types and constants for the ALU command engine.
// Revision : 1.0 - initial release
// ============================================================================
package alu_cmd_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_NOTA = 3'b100,
      OP_XOR  = 3'b101,
      OP_NAND = 3'b110,
      OP_NOR  = 3'b111
   } opcode_t;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      opcode_t    s;
   } cmd_t;

   localparam int c_FIFO_DEPTH = 4;
   localparam int c_PTR_W      = $clog2(c_FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_STALL = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_core
// Purpose  : Combinational 4-bit ALU; carry/borrow output exists only when
//            ALU_CMD_FLAGS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_core
   import alu_cmd_pkg::*;
(
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  opcode_t    i_s,
   output logic [3:0] o_c
`ifdef ALU_CMD_FLAGS_EN
   ,
   output logic       o_carry
`endif
);

`ifdef ALU_CMD_FLAGS_EN
   // Fifth bit of the sum is carry-out; fifth bit of the difference is borrow.
   logic [4:0] w_sum;
   logic [4:0] w_diff;
   assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
   assign o_carry = (i_s == OP_ADD) ? w_sum[4]  :
                    (i_s == OP_SUB) ? w_diff[4] : 1'b0;
`else
   logic [3:0] w_sum;
   logic [3:0] w_diff;
   assign w_sum  = i_a + i_b;
   assign w_diff = i_a - i_b;
`endif

   always_comb begin
      o_c = 4'h0;
      case (i_s)
         OP_ADD:  o_c = w_sum[3:0];
         OP_SUB:  o_c = w_diff[3:0];
         OP_AND:  o_c = i_a & i_b;
         OP_OR:   o_c = i_a | i_b;
         OP_NOTA: o_c = ~i_a;
         OP_XOR:  o_c = i_a ^ i_b;
         OP_NAND: o_c = ~(i_a & i_b);
         OP_NOR:  o_c = ~(i_a | i_b);
         default: o_c = 4'h0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_engine
// Purpose  : 4-deep command FIFO feeding a registered ALU result stage with
//            valid/ready handshakes; flags enabled by ALU_CMD_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_engine
   import alu_cmd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_a,
   input  logic [3:0] in_b,
   input  logic [2:0] in_s,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_c,
   output logic       out_zero,
   output logic       out_carry,
   output logic [7:0] done_count
);

   localparam logic [c_PTR_W:0] c_CNT_FULL = (c_PTR_W + 1)'(c_FIFO_DEPTH);

   cmd_t                r_mem [c_FIFO_DEPTH];
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_PTR_W:0]    r_cnt;
   state_t              r_state;
   logic                r_out_valid;
   logic [3:0]          r_out_c;
   logic [7:0]          r_done_count;

   state_t              w_state_nxt;
   logic                w_push;
   logic                w_pop;
   logic                w_out_hs;
   logic                w_vld_nxt;
   logic [c_PTR_W:0]    w_cnt_nxt;
   cmd_t                w_in_cmd;
   cmd_t                w_head;
   logic [3:0]          w_c;

   assign in_ready   = (r_cnt != c_CNT_FULL);
   assign w_in_cmd   = '{a: in_a, b: in_b, s: opcode_t'(in_s)};
   assign w_head     = r_mem[r_rd_ptr];
   assign out_valid  = r_out_valid;
   assign out_c      = r_out_c;
   assign done_count = r_done_count;

`ifdef ALU_CMD_FLAGS_EN
   logic w_carry;
   logic r_out_zero;
   logic r_out_carry;

   alu_cmd_core u_core (
      .i_a     (w_head.a),
      .i_b     (w_head.b),
      .i_s     (w_head.s),
      .o_c     (w_c),
      .o_carry (w_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_zero  <= 1'b0;
         r_out_carry <= 1'b0;
      end else if (w_pop) begin
         r_out_zero  <= (w_c == 4'h0);
         r_out_carry <= w_carry;
      end
   end

   assign out_zero  = r_out_zero;
   assign out_carry = r_out_carry;
`else
   alu_cmd_core u_core (
      .i_a (w_head.a),
      .i_b (w_head.b),
      .i_s (w_head.s),
      .o_c (w_c)
   );

   assign out_zero  = 1'b0;
   assign out_carry = 1'b0;
`endif

   // State tracks next-cycle occupancy: STALL means a result is held while
   // commands wait behind it, so only out_ready can release a pop.
   always_comb begin
      w_push      = in_valid && in_ready;
      w_pop       = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         ST_ISSUE: w_pop = (r_cnt != '0) && (!r_out_valid || out_ready);
         ST_STALL: w_pop = out_ready;
         default:  w_pop = 1'b0;
      endcase
      w_out_hs  = r_out_valid && out_ready;
      w_vld_nxt = w_pop || (r_out_valid && !out_ready);
      w_cnt_nxt = r_cnt + {{c_PTR_W{1'b0}}, w_push} - {{c_PTR_W{1'b0}}, w_pop};
      if (!w_vld_nxt && (w_cnt_nxt == '0)) begin
         w_state_nxt = ST_IDLE;
      end else if (w_vld_nxt && (w_cnt_nxt != '0)) begin
         w_state_nxt = ST_STALL;
      end else begin
         w_state_nxt = ST_ISSUE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_cnt        <= '0;
         r_out_valid  <= 1'b0;
         r_out_c      <= 4'h0;
         r_done_count <= 8'h00;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_out_valid <= w_vld_nxt;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_out_c  <= w_c;
         end
         if (w_out_hs) begin
            r_done_count <= r_done_count + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_in_cmd;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_engine
// Purpose  : Self-checking bench for alu_cmd_engine against a queue model;
//            honours ALU_CMD_FLAGS_EN for flag expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_engine;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic [2:0] in_s;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_c;
   logic       out_zero;
   logic       out_carry;
   logic [7:0] done_count;

   alu_cmd_engine dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_s       (in_s),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_c      (out_c),
      .out_zero   (out_zero),
      .out_carry  (out_carry),
      .done_count (done_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef ALU_CMD_FLAGS_EN
   localparam int c_FLAGS_ON = 1;
`else
   localparam int c_FLAGS_ON = 0;
`endif

   int n_total = 0;
   int n_bad   = 0;

   // Model: pending commands, result register contents, handshake count.
   logic [10:0] m_fifo[$];
   int          m_valid;
   int          m_c;
   int          m_z;
   int          m_cy;
   int          m_done;
   int          hs_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void ref_alu(input int a, input int b, input int s,
                                   output int c, output int cy);
      cy = 0;
      case (s)
         0: begin c = (a + b) % 16; cy = (a + b > 15) ? 1 : 0; end
         1: begin c = (a - b + 16) % 16; cy = (a < b) ? 1 : 0; end
         2: c = a & b;
         3: c = a | b;
         4: c = 15 - a;
         5: c = a ^ b;
         6: c = 15 - (a & b);
         default: c = 15 - (a | b);
      endcase
   endfunction

   function automatic void model_reset();
      m_fifo.delete();
      m_valid = 0;
      m_c     = 0;
      m_z     = 0;
      m_cy    = 0;
      m_done  = 0;
   endfunction

   task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] s, input logic ordy, input logic r);
      int  c, cy;
      bit  push, pop, hs;
      logic [10:0] cmd;
      rst       = r;
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_s      = s;
      out_ready = ordy;
      hs_seen   = (v && in_ready) ? 1 : 0;
      if (r) begin
         model_reset();
      end else begin
         push = v && (m_fifo.size() < 4);
         hs   = (m_valid != 0) && ordy;
         pop  = (m_fifo.size() > 0) && ((m_valid == 0) || ordy);
         if (hs) m_done = (m_done + 1) % 256;
         if (pop) begin
            cmd = m_fifo.pop_front();
            ref_alu(int'(cmd[10:7]), int'(cmd[6:3]), int'(cmd[2:0]), c, cy);
            m_c     = c;
            m_z     = (c == 0) ? c_FLAGS_ON : 0;
            m_cy    = cy * c_FLAGS_ON;
            m_valid = 1;
         end else if (hs) begin
            m_valid = 0;
         end
         if (push) m_fifo.push_back({a, b, s});
      end
      @(posedge clk);
      #1;
      check("in_ready",   in_ready,   (m_fifo.size() < 4) ? 1 : 0);
      check("out_valid",  out_valid,  m_valid);
      check("out_c",      out_c,      m_c);
      check("out_zero",   out_zero,   m_z);
      check("out_carry",  out_carry,  m_cy);
      check("done_count", done_count, m_done);
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 4'h0, 4'h0, 3'b000, ordy, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 4'h0, 4'h0, 3'b000, 1'b0, 1'b1);
   endtask

   initial begin
      int acc;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_s = '0; out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;

      do_reset();
      check("rst_c", out_c, 0);
      check("rst_rdy", in_ready, 1);

      // Add with two-edge latency.
      step(1'b1, 4'hA, 4'h4, 3'b000, 1'b1, 1'b0);
      check("add_lat0", out_valid, 0);
      idle(1'b1);
      check("add_vld", out_valid, 1);
      check("add_c", out_c, 4'hE);
      check("add_zero", out_zero, 0);
      check("add_cy", out_carry, 0);
      idle(1'b1);

      step(1'b1, 4'h0, 4'h1, 3'b001, 1'b1, 1'b0);
      idle(1'b1);
      check("sub_c", out_c, 4'hF);
      check("sub_borrow", out_carry, c_FLAGS_ON);
      idle(1'b1);

      step(1'b1, 4'hC, 4'hC, 3'b101, 1'b1, 1'b0);
      idle(1'b1);
      check("xor_c", out_c, 4'h0);
      check("xor_zero", out_zero, c_FLAGS_ON);
      idle(1'b1);

      // Backpressure: only five commands fit.
      do_reset();
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 4'(i + 3), 4'(7 - i), 3'(i), 1'b0, 1'b0);
         acc += hs_seen;
      end
      check("bp_accepted", acc, 5);
      check("bp_rdy", in_ready, 0);
      check("bp_vld", out_valid, 1);
      for (int i = 0; i < 8; i++) idle(1'b1);
      check("bp_done", done_count, 5);
      check("bp_drained", out_valid, 0);

      // Reset with work in flight.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 4'(i), 4'(i + 1), 3'b000, 1'b0, 1'b0);
      check("mid_vld1", out_valid, 1);
      step(1'b1, 4'h5, 4'h5, 3'b000, 1'b1, 1'b1);
      check("mid_vld0", out_valid, 0);
      check("mid_done", done_count, 0);
      check("mid_rdy", in_ready, 1);
      for (int i = 0; i < 5; i++) idle(1'b1);
      check("mid_stale", out_valid, 0);

      // 256 back-to-back handshakes wrap the counter.
      do_reset();
      for (int i = 0; i < 256; i++)
         step(1'b1, 4'($urandom), 4'($urandom), 3'($urandom), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) idle(1'b1);
      check("wrap_done", done_count, 0);
      check("wrap_vld", out_valid, 0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 3'($urandom),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 199) == 0));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
